// File: rtl/mult_rs.sv
// Reservation station for the pipelined integer multiplier: holds operations until operands arrive,
// dispatches them in order of entry index and forwards results to the CDB. Optional: MULT_RS_ISSUE_BYPASS_EN.
module mult_rs #(
    parameter int DEPTH           = 4,
    parameter int EU_CTL_LEN      = 4,
    parameter int XLEN            = 32,
    parameter int ROB_IDX_LEN     = 4,
    parameter int EXCEPT_CODE_LEN = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [EU_CTL_LEN-1:0]      issue_eu_ctl_i,
    input  logic                       issue_rs1_ready_i,
    input  logic [ROB_IDX_LEN-1:0]     issue_rs1_idx_i,
    input  logic [XLEN-1:0]            issue_rs1_value_i,
    input  logic                       issue_rs2_ready_i,
    input  logic [ROB_IDX_LEN-1:0]     issue_rs2_idx_i,
    input  logic [XLEN-1:0]            issue_rs2_value_i,
    input  logic [ROB_IDX_LEN-1:0]     issue_dest_idx_i,
    input  logic                       cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0]     cdb_idx_i,
    input  logic [XLEN-1:0]            cdb_value_i,
    output logic                       eu_valid_o,
    input  logic                       eu_ready_i,
    output logic [EU_CTL_LEN-1:0]      eu_ctl_o,
    output logic [ROB_IDX_LEN-1:0]     eu_rob_idx_o,
    output logic [XLEN-1:0]            eu_rs1_value_o,
    output logic [XLEN-1:0]            eu_rs2_value_o,
    input  logic                       eu_valid_i,
    output logic                       eu_ready_o,
    input  logic [ROB_IDX_LEN-1:0]     eu_rob_idx_i,
    input  logic [XLEN-1:0]            eu_result_i,
    input  logic                       eu_except_raised_i,
    input  logic [EXCEPT_CODE_LEN-1:0] eu_except_code_i,
    output logic                       cdb_valid_o,
    input  logic                       cdb_ready_i,
    output logic [ROB_IDX_LEN-1:0]     cdb_idx_o,
    output logic [XLEN-1:0]            cdb_value_o,
    output logic                       cdb_except_raised_o,
    output logic [EXCEPT_CODE_LEN-1:0] cdb_except_code_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        EMPTY     = 3'd0,
        WAIT_OPS  = 3'd1,
        READY     = 3'd2,
        EXECUTING = 3'd3,
        COMPLETED = 3'd4
    } entry_state_t;

    typedef struct packed {
        entry_state_t               state;
        logic [EU_CTL_LEN-1:0]      ctl;
        logic [ROB_IDX_LEN-1:0]     dest_idx;
        logic                       rs1_ready;
        logic [ROB_IDX_LEN-1:0]     rs1_idx;
        logic [XLEN-1:0]            rs1_value;
        logic                       rs2_ready;
        logic [ROB_IDX_LEN-1:0]     rs2_idx;
        logic [XLEN-1:0]            rs2_value;
        logic [XLEN-1:0]            result;
        logic                       except_raised;
        logic [EXCEPT_CODE_LEN-1:0] except_code;
    } entry_t;

    entry_t             entry_r [DEPTH];
    entry_t             entry_s [DEPTH];
    logic               stall_r;
    logic [IDX_W-1:0]   stall_idx_r;

    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               ready_found_s;
    logic [IDX_W-1:0]   ready_idx_s;
    logic               done_found_s;
    logic [IDX_W-1:0]   done_idx_s;
    logic [DEPTH-1:0]   rs1_hit_s;
    logic [DEPTH-1:0]   rs2_hit_s;

    logic               disp_valid_s;
    logic [IDX_W-1:0]   disp_idx_s;
    logic               dispatch_fire_s;
    logic               wb_fire_s;
    logic               alloc_s;
    logic               bypass_s;
    logic               alloc_rs1_ready_s;
    logic               alloc_rs2_ready_s;
    logic [XLEN-1:0]    alloc_rs1_value_s;
    logic [XLEN-1:0]    alloc_rs2_value_s;

    // Priority encoders (lowest index wins) and per-entry CDB tag matches.
    always_comb begin
        free_found_s  = 1'b0;
        free_idx_s    = '0;
        ready_found_s = 1'b0;
        ready_idx_s   = '0;
        done_found_s  = 1'b0;
        done_idx_s    = '0;
        rs1_hit_s     = '0;
        rs2_hit_s     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_r[i].state == EMPTY) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
            if (entry_r[i].state == READY) begin
                ready_found_s = 1'b1;
                ready_idx_s   = IDX_W'(i);
            end else begin
                ready_found_s = ready_found_s;
            end
            if (entry_r[i].state == COMPLETED) begin
                done_found_s = 1'b1;
                done_idx_s   = IDX_W'(i);
            end else begin
                done_found_s = done_found_s;
            end
            rs1_hit_s[i] = !entry_r[i].rs1_ready && cdb_valid_i && (cdb_idx_i == entry_r[i].rs1_idx);
            rs2_hit_s[i] = !entry_r[i].rs2_ready && cdb_valid_i && (cdb_idx_i == entry_r[i].rs2_idx);
        end
    end

    // A stalled request keeps its entry even if a lower-index entry becomes READY meanwhile.
    assign disp_valid_s    = stall_r ? (entry_r[stall_idx_r].state == READY) : ready_found_s;
    assign disp_idx_s      = stall_r ? stall_idx_r : ready_idx_s;
    assign dispatch_fire_s = disp_valid_s && eu_ready_i && !flush_i;
    assign wb_fire_s       = done_found_s && cdb_ready_i;

    assign issue_ready_o     = free_found_s;
    assign alloc_s           = issue_valid_i && free_found_s && !flush_i;
    assign alloc_rs1_ready_s = issue_rs1_ready_i || (cdb_valid_i && (cdb_idx_i == issue_rs1_idx_i));
    assign alloc_rs2_ready_s = issue_rs2_ready_i || (cdb_valid_i && (cdb_idx_i == issue_rs2_idx_i));
    assign alloc_rs1_value_s = issue_rs1_ready_i ? issue_rs1_value_i : cdb_value_i;
    assign alloc_rs2_value_s = issue_rs2_ready_i ? issue_rs2_value_i : cdb_value_i;

`ifdef MULT_RS_ISSUE_BYPASS_EN
    assign bypass_s = alloc_s && issue_rs1_ready_i && issue_rs2_ready_i && !ready_found_s && eu_ready_i;
`else
    assign bypass_s = 1'b0;
`endif

    // Dispatch port: bypassed issue has priority (only possible when nothing is READY).
    always_comb begin
        eu_valid_o     = 1'b0;
        eu_ctl_o       = '0;
        eu_rob_idx_o   = '0;
        eu_rs1_value_o = '0;
        eu_rs2_value_o = '0;
        if (bypass_s) begin
            eu_valid_o     = 1'b1;
            eu_ctl_o       = issue_eu_ctl_i;
            eu_rob_idx_o   = issue_dest_idx_i;
            eu_rs1_value_o = issue_rs1_value_i;
            eu_rs2_value_o = issue_rs2_value_i;
        end else if (disp_valid_s) begin
            eu_valid_o     = 1'b1;
            eu_ctl_o       = entry_r[disp_idx_s].ctl;
            eu_rob_idx_o   = entry_r[disp_idx_s].dest_idx;
            eu_rs1_value_o = entry_r[disp_idx_s].rs1_value;
            eu_rs2_value_o = entry_r[disp_idx_s].rs2_value;
        end else begin
            eu_valid_o = 1'b0;
        end
    end

    assign eu_ready_o = 1'b1;

    // Writeback port: lowest-index completed entry.
    always_comb begin
        cdb_valid_o         = 1'b0;
        cdb_idx_o           = '0;
        cdb_value_o         = '0;
        cdb_except_raised_o = 1'b0;
        cdb_except_code_o   = '0;
        if (done_found_s) begin
            cdb_valid_o         = 1'b1;
            cdb_idx_o           = entry_r[done_idx_s].dest_idx;
            cdb_value_o         = entry_r[done_idx_s].result;
            cdb_except_raised_o = entry_r[done_idx_s].except_raised;
            cdb_except_code_o   = entry_r[done_idx_s].except_code;
        end else begin
            cdb_valid_o = 1'b0;
        end
    end

    // Per-entry next state: all events on different entries apply in the same cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_s[i] = entry_r[i];
            if (flush_i) begin
                entry_s[i].state = EMPTY;
            end else begin
                case (entry_r[i].state)
                    EMPTY: begin
                        if (alloc_s && (free_idx_s == IDX_W'(i))) begin
                            entry_s[i].ctl           = issue_eu_ctl_i;
                            entry_s[i].dest_idx      = issue_dest_idx_i;
                            entry_s[i].rs1_ready     = alloc_rs1_ready_s;
                            entry_s[i].rs1_idx       = issue_rs1_idx_i;
                            entry_s[i].rs1_value     = alloc_rs1_value_s;
                            entry_s[i].rs2_ready     = alloc_rs2_ready_s;
                            entry_s[i].rs2_idx       = issue_rs2_idx_i;
                            entry_s[i].rs2_value     = alloc_rs2_value_s;
                            entry_s[i].result        = '0;
                            entry_s[i].except_raised = 1'b0;
                            entry_s[i].except_code   = '0;
                            if (bypass_s) begin
                                entry_s[i].state = EXECUTING;
                            end else if (alloc_rs1_ready_s && alloc_rs2_ready_s) begin
                                entry_s[i].state = READY;
                            end else begin
                                entry_s[i].state = WAIT_OPS;
                            end
                        end else begin
                            entry_s[i].state = EMPTY;
                        end
                    end
                    WAIT_OPS: begin
                        entry_s[i].rs1_ready = entry_r[i].rs1_ready || rs1_hit_s[i];
                        entry_s[i].rs1_value = rs1_hit_s[i] ? cdb_value_i : entry_r[i].rs1_value;
                        entry_s[i].rs2_ready = entry_r[i].rs2_ready || rs2_hit_s[i];
                        entry_s[i].rs2_value = rs2_hit_s[i] ? cdb_value_i : entry_r[i].rs2_value;
                        entry_s[i].state = ((entry_r[i].rs1_ready || rs1_hit_s[i]) &&
                                            (entry_r[i].rs2_ready || rs2_hit_s[i])) ? READY : WAIT_OPS;
                    end
                    READY: begin
                        entry_s[i].state = (dispatch_fire_s && (disp_idx_s == IDX_W'(i))) ? EXECUTING : READY;
                    end
                    EXECUTING: begin
                        if (eu_valid_i && (entry_r[i].dest_idx == eu_rob_idx_i)) begin
                            entry_s[i].result        = eu_result_i;
                            entry_s[i].except_raised = eu_except_raised_i;
                            entry_s[i].except_code   = eu_except_code_i;
                            entry_s[i].state         = COMPLETED;
                        end else begin
                            entry_s[i].state = EXECUTING;
                        end
                    end
                    COMPLETED: begin
                        entry_s[i].state = (wb_fire_s && (done_idx_s == IDX_W'(i))) ? EMPTY : COMPLETED;
                    end
                    default: begin
                        entry_s[i] = '0;
                    end
                endcase
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= entry_s[i];
            end
        end
    end

    // Dispatch lock: remembers which entry is waiting on eu_ready_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_r     <= 1'b0;
            stall_idx_r <= '0;
        end else if (flush_i) begin
            stall_r     <= 1'b0;
            stall_idx_r <= '0;
        end else begin
            stall_r     <= disp_valid_s && !eu_ready_i;
            stall_idx_r <= disp_idx_s;
        end
    end

endmodule

// File: tb/tb_mult_rs.sv
// Directed self-checking bench for mult_rs: issue/dispatch/result/writeback, CDB capture,
// full RS back-pressure, dispatch stall locking, exceptions and flush.
module tb_mult_rs;

    localparam logic [3:0] E_ILLEGAL_INSTRUCTION = 4'd2;
`ifdef MULT_RS_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [3:0]  issue_eu_ctl_i = '0;
    logic        issue_rs1_ready_i = 1'b0;
    logic [3:0]  issue_rs1_idx_i = '0;
    logic [31:0] issue_rs1_value_i = '0;
    logic        issue_rs2_ready_i = 1'b0;
    logic [3:0]  issue_rs2_idx_i = '0;
    logic [31:0] issue_rs2_value_i = '0;
    logic [3:0]  issue_dest_idx_i = '0;
    logic        cdb_valid_i = 1'b0;
    logic [3:0]  cdb_idx_i = '0;
    logic [31:0] cdb_value_i = '0;
    logic        eu_valid_o;
    logic        eu_ready_i = 1'b0;
    logic [3:0]  eu_ctl_o;
    logic [3:0]  eu_rob_idx_o;
    logic [31:0] eu_rs1_value_o;
    logic [31:0] eu_rs2_value_o;
    logic        eu_valid_i = 1'b0;
    logic        eu_ready_o;
    logic [3:0]  eu_rob_idx_i = '0;
    logic [31:0] eu_result_i = '0;
    logic        eu_except_raised_i = 1'b0;
    logic [3:0]  eu_except_code_i = '0;
    logic        cdb_valid_o;
    logic        cdb_ready_i = 1'b0;
    logic [3:0]  cdb_idx_o;
    logic [31:0] cdb_value_o;
    logic        cdb_except_raised_o;
    logic [3:0]  cdb_except_code_o;

    int checks = 0;
    int failures = 0;

    mult_rs dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_eu_ctl_i(issue_eu_ctl_i),
        .issue_rs1_ready_i(issue_rs1_ready_i), .issue_rs1_idx_i(issue_rs1_idx_i), .issue_rs1_value_i(issue_rs1_value_i),
        .issue_rs2_ready_i(issue_rs2_ready_i), .issue_rs2_idx_i(issue_rs2_idx_i), .issue_rs2_value_i(issue_rs2_value_i),
        .issue_dest_idx_i(issue_dest_idx_i),
        .cdb_valid_i(cdb_valid_i), .cdb_idx_i(cdb_idx_i), .cdb_value_i(cdb_value_i),
        .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_ctl_o(eu_ctl_o), .eu_rob_idx_o(eu_rob_idx_o),
        .eu_rs1_value_o(eu_rs1_value_o), .eu_rs2_value_o(eu_rs2_value_o),
        .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_rob_idx_i(eu_rob_idx_i), .eu_result_i(eu_result_i),
        .eu_except_raised_i(eu_except_raised_i), .eu_except_code_i(eu_except_code_i),
        .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_idx_o(cdb_idx_o), .cdb_value_o(cdb_value_o),
        .cdb_except_raised_o(cdb_except_raised_o), .cdb_except_code_o(cdb_except_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i      = 1'b0;
        cdb_valid_i        = 1'b0;
        eu_valid_i         = 1'b0;
        eu_except_raised_i = 1'b0;
        eu_except_code_i   = '0;
        flush_i            = 1'b0;
    endtask

    task automatic issue_op(input logic [3:0] ctl, input logic r1rdy, input logic [3:0] r1idx,
                            input logic [31:0] r1val, input logic r2rdy, input logic [3:0] r2idx,
                            input logic [31:0] r2val, input logic [3:0] dest);
        issue_valid_i     = 1'b1;
        issue_eu_ctl_i    = ctl;
        issue_rs1_ready_i = r1rdy;
        issue_rs1_idx_i   = r1idx;
        issue_rs1_value_i = r1val;
        issue_rs2_ready_i = r2rdy;
        issue_rs2_idx_i   = r2idx;
        issue_rs2_value_i = r2val;
        issue_dest_idx_i  = dest;
    endtask

    task automatic cdb_bcast(input logic [3:0] idx, input logic [31:0] val);
        cdb_valid_i = 1'b1;
        cdb_idx_i   = idx;
        cdb_value_i = val;
    endtask

    task automatic eu_result(input logic [3:0] idx, input logic [31:0] res, input logic exc, input logic [3:0] code);
        eu_valid_i         = 1'b1;
        eu_rob_idx_i       = idx;
        eu_result_i        = res;
        eu_except_raised_i = exc;
        eu_except_code_i   = code;
    endtask

    initial begin
        // Reset values
        #12;
        check_eq("rst_issue_ready", issue_ready_o, 1);
        check_eq("rst_eu_valid", eu_valid_o, 0);
        check_eq("rst_cdb_valid", cdb_valid_o, 0);
        check_eq("rst_eu_ready", eu_ready_o, 1);
        check_eq("rst_eu_rob_idx", eu_rob_idx_o, 0);
        check_eq("rst_cdb_value", cdb_value_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // MUL 3*5 -> dest 2, dispatch next cycle, result at +4, CDB at +5
        eu_ready_i = 1'b1;
        issue_op(4'd0, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd5, 4'd2);
        #1;
        check_eq("mul_c0_eu_valid", eu_valid_o, BYP ? 1 : 0);
        check_eq("mul_c0_rob", eu_rob_idx_o, BYP ? 2 : 0);
        tick(); idle();
        check_eq("mul_c1_eu_valid", eu_valid_o, BYP ? 0 : 1);
        check_eq("mul_c1_rob", eu_rob_idx_o, BYP ? 0 : 2);
        check_eq("mul_c1_rs1", eu_rs1_value_o, BYP ? 0 : 3);
        check_eq("mul_c1_rs2", eu_rs2_value_o, BYP ? 0 : 5);
        tick();
        check_eq("mul_c2_eu_valid", eu_valid_o, 0);
        tick(); tick();
        eu_result(4'd2, 32'd15, 1'b0, 4'd0);
        check_eq("mul_c4_cdb_valid", cdb_valid_o, 0);
        tick(); idle();
        check_eq("mul_c5_cdb_valid", cdb_valid_o, 1);
        check_eq("mul_c5_cdb_idx", cdb_idx_o, 2);
        check_eq("mul_c5_cdb_value", cdb_value_o, 15);
        check_eq("mul_c5_cdb_exc", cdb_except_raised_o, 0);
        cdb_ready_i = 1'b1;
        tick();
        cdb_ready_i = 1'b0;
        check_eq("mul_retired", cdb_valid_o, 0);

        // MULH with rs1 captured from the CDB in the allocation cycle
        eu_ready_i = 1'b0;
        issue_op(4'd1, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd2, 4'd3);
        cdb_bcast(4'd7, 32'h10);
        tick(); idle();
        check_eq("byp_cdb_eu_valid", eu_valid_o, 1);
        check_eq("byp_cdb_rs1", eu_rs1_value_o, 32'h10);
        check_eq("byp_cdb_rs2", eu_rs2_value_o, 2);
        check_eq("byp_cdb_ctl", eu_ctl_o, 1);
        check_eq("byp_cdb_rob", eu_rob_idx_o, 3);
        eu_ready_i = 1'b1;
        tick();
        eu_ready_i = 1'b0;
        check_eq("mulh_dispatched", eu_valid_o, 0);
        eu_result(4'd3, 32'h20, 1'b0, 4'd0);
        cdb_ready_i = 1'b1;
        tick(); idle();
        check_eq("mulh_cdb_value", cdb_value_o, 32'h20);
        check_eq("mulh_cdb_idx", cdb_idx_o, 3);
        tick();
        cdb_ready_i = 1'b0;
        check_eq("mulh_retired", cdb_valid_o, 0);

        // Fill all entries with rs1 pending on tags 12..15, dests 4..7
        for (int k = 0; k < 4; k++) begin
            issue_op(4'd2, 1'b0, 4'(12 + k), 32'd0, 1'b1, 4'd0, 32'd7, 4'(4 + k));
            tick();
        end
        idle();
        check_eq("full_issue_ready", issue_ready_o, 0);
        issue_op(4'd2, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd8);
        tick(); idle();
        check_eq("full_reject_eu_valid", eu_valid_o, 0);
        check_eq("full_reject_ready", issue_ready_o, 0);
        cdb_bcast(4'd12, 32'd9);
        tick(); idle();
        check_eq("full_wake_eu_valid", eu_valid_o, 1);
        check_eq("full_wake_rob", eu_rob_idx_o, 4);
        check_eq("full_wake_rs1", eu_rs1_value_o, 9);
        eu_ready_i = 1'b1;
        tick();
        eu_ready_i = 1'b0;
        check_eq("full_disp_eu_valid", eu_valid_o, 0);
        eu_result(4'd4, 32'd0, 1'b1, E_ILLEGAL_INSTRUCTION);
        tick(); idle();
        check_eq("exc_cdb_valid", cdb_valid_o, 1);
        check_eq("exc_cdb_idx", cdb_idx_o, 4);
        check_eq("exc_cdb_raised", cdb_except_raised_o, 1);
        check_eq("exc_cdb_code", cdb_except_code_o, E_ILLEGAL_INSTRUCTION);
        check_eq("exc_still_full", issue_ready_o, 0);
        cdb_ready_i = 1'b1;
        tick();
        cdb_ready_i = 1'b0;
        check_eq("freed_issue_ready", issue_ready_o, 1);
        check_eq("freed_cdb_valid", cdb_valid_o, 0);

        // Stall: entry 1 requests; entries 0 and 2 become READY while it is stalled
        cdb_bcast(4'd13, 32'd1);
        tick(); idle();
        check_eq("stall0_rob", eu_rob_idx_o, 5);
        issue_op(4'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd6, 4'd9);
        cdb_bcast(4'd14, 32'd2);
        tick(); idle();
        check_eq("stall1_valid", eu_valid_o, 1);
        check_eq("stall1_rob", eu_rob_idx_o, 5);
        tick();
        check_eq("stall2_rob", eu_rob_idx_o, 5);
        check_eq("stall2_rs1", eu_rs1_value_o, 1);
        tick();
        check_eq("stall3_rob", eu_rob_idx_o, 5);
        check_eq("stall3_ctl", eu_ctl_o, 2);
        eu_ready_i = 1'b1;
        tick();
        check_eq("rel1_rob", eu_rob_idx_o, 9);
        check_eq("rel1_rs1", eu_rs1_value_o, 4);
        check_eq("rel1_rs2", eu_rs2_value_o, 6);
        tick();
        check_eq("rel2_rob", eu_rob_idx_o, 6);
        check_eq("rel2_rs1", eu_rs1_value_o, 2);
        tick();
        eu_ready_i = 1'b0;
        check_eq("rel3_eu_valid", eu_valid_o, 0);

        // Flush with WAIT_OPS (tag 15), EXECUTING (9, 6) and COMPLETED (5) entries
        eu_result(4'd5, 32'h55, 1'b0, 4'd0);
        tick(); idle();
        check_eq("pre_flush_cdb_valid", cdb_valid_o, 1);
        check_eq("pre_flush_cdb_value", cdb_value_o, 32'h55);
        flush_i = 1'b1;
        eu_result(4'd9, 32'h99, 1'b0, 4'd0);
        tick(); idle();
        check_eq("flush_eu_valid", eu_valid_o, 0);
        check_eq("flush_cdb_valid", cdb_valid_o, 0);
        check_eq("flush_issue_ready", issue_ready_o, 1);
        eu_result(4'd6, 32'h66, 1'b0, 4'd0);
        cdb_bcast(4'd15, 32'd3);
        tick(); idle();
        check_eq("late_cdb_valid", cdb_valid_o, 0);
        check_eq("late_eu_valid", eu_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_rs.md
# mult_rs

Reservation station feeding the pipelined integer multiplier. It accepts MUL/MULH/MULHU/MULHSU/MULW operations from the issue stage and holds each one until both source operands are available. Operands arrive either with the instruction or from the common data bus (CDB). Ready operations are dispatched to the multiplier with a valid/ready handshake, the multiplier results are captured by ROB index, and completed results are forwarded to the CDB.

## Interface
Parameters:
- DEPTH, 4: number of RS entries (≥2).
- EU_CTL_LEN, 4: width of the multiplier opcode field; passed through unchanged.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of all entries.
- issue_valid_i  in  1  new operation offered.
- issue_ready_o  out  1  a free entry exists.
- issue_eu_ctl_i  in  EU_CTL_LEN  multiplier opcode.
- issue_rs1_ready_i / issue_rs2_ready_i  in  1 each  operand value is valid.
- issue_rs1_idx_i / issue_rs2_idx_i  in  rob_idx_t  producer tag, used when not ready.
- issue_rs1_value_i / issue_rs2_value_i  in  XLEN  operand value.
- issue_dest_idx_i  in  rob_idx_t  ROB index of the operation.
- cdb_valid_i  in  1  CDB broadcast valid.
- cdb_idx_i  in  rob_idx_t  broadcast tag.
- cdb_value_i  in  XLEN  broadcast value.
- eu_valid_o  out  1  dispatch valid.
- eu_ready_i  in  1  multiplier accepts.
- eu_ctl_o  out  EU_CTL_LEN  opcode to multiplier.
- eu_rob_idx_o  out  rob_idx_t  dispatched ROB index.
- eu_rs1_value_o / eu_rs2_value_o  out  XLEN  operands to multiplier.
- eu_valid_i  in  1  multiplier result valid.
- eu_ready_o  out  1  result accepted; tied to 1.
- eu_rob_idx_i  in  rob_idx_t  result tag.
- eu_result_i  in  XLEN  multiplier result.
- eu_except_raised_i  in  1  multiplier exception flag.
- eu_except_code_i  in  except_code_t  multiplier exception code.
- cdb_valid_o  out  1  completed result offered to CDB.
- cdb_ready_i  in  1  CDB arbiter grant.
- cdb_idx_o  out  rob_idx_t  result tag.
- cdb_value_o  out  XLEN  result value.
- cdb_except_raised_o  out  1  exception flag.
- cdb_except_code_o  out  except_code_t  exception code.

## Operation
- Each entry has a state: EMPTY, WAIT_OPS, READY, EXECUTING or COMPLETED. The entry also holds ctl, dest_idx, per-operand ready/idx/value, result, except_raised and except_code.

Allocation:
- Allocation happens on issue_valid_i && issue_ready_o && !flush_i.
- The new operation goes into the lowest-index EMPTY entry.
- The entry becomes READY if both operands are ready, otherwise WAIT_OPS.
- issue_ready_o = any entry EMPTY. It depends on registered state only and does not see same-cycle frees.

Operand capture:
- Every cycle, each not-ready operand of a WAIT_OPS entry whose tag equals cdb_idx_i while cdb_valid_i is high latches cdb_value_i.
- A WAIT_OPS entry becomes READY once both operands are ready.
- This capture also applies to the operation being allocated in the same cycle: a not-ready input operand whose tag matches the CDB is stored as ready.

Dispatch:
- The lowest-index READY entry drives eu_*_o, with eu_valid_o = 1.
- On eu_ready_i the entry moves READY→EXECUTING.
- eu_valid_o never drops while eu_ready_i is low unless flush_i is high.
- The selection does not change while a request is stalled.

Result capture:
- On eu_valid_i, the EXECUTING entry whose dest_idx equals eu_rob_idx_i stores the result and exception fields and moves to COMPLETED.
- Entries are allocated only for unique ROB indices, so at most one entry can match.

Writeback:
- The lowest-index COMPLETED entry drives cdb_*_o, with cdb_valid_o = 1.
- On cdb_ready_i the entry moves to EMPTY.

Flush:
- All entries go to EMPTY at the next edge.
- EU results arriving in the same cycle as the flush are discarded.
- The multiplier is flushed by the same flush_i signal.

## Timing
- Reset values: issue_ready_o=1 (all entries EMPTY). eu_valid_o=0, cdb_valid_o=0, eu_ready_o=1. All data outputs are 0.
- Minimum latency from issue to dispatch: 1 cycle, i.e. eu_valid_o rises the cycle after allocation (except with the bypass, see Configuration).
- Result latency: the multiplier's. A completed entry drives cdb_valid_o in the cycle after eu_valid_i.
- Full RS: issue_ready_o=0. An entry freed by cdb_ready_i makes issue_ready_o=1 in the next cycle.
- Simultaneous events in one cycle on different entries are all applied: allocation, CDB capture, dispatch, result capture and writeback.
- Reset mid-operation clears everything asynchronously; in-flight EU results are lost.

## Configuration
- MULT_RS_ISSUE_BYPASS_EN, defined:
  - Condition: the allocated operation has both operands ready at the input, no entry is READY, and eu_ready_i is high.
  - Effect: the operation is dispatched in the allocation cycle. eu_*_o are driven combinationally from issue_*_i and the entry is written directly as EXECUTING.
- MULT_RS_ISSUE_BYPASS_EN, undefined: every operation spends at least one cycle in READY.

## Test plan
- After reset: issue MUL, rs1=3, rs2=5, both ready, dest=2, with eu_ready_i=1. Required: eu_valid_o at cycle+1 (cycle+0 with the bypass), eu_rob_idx_o=2. Return result 15 at cycle+4. Required: cdb_valid_o with value 15, idx 2 at cycle+5.
- Issue MULH with rs1 waiting on tag 7; broadcast tag 7, value 0x10 in the same cycle as allocation. Required: the entry is READY the next cycle and eu_rs1_value_o=0x10.
- Fill all DEPTH entries with operands pending. Required: issue_ready_o=0 and a further issue_valid_i is ignored. Complete one entry and retire it on the CDB. Required: issue_ready_o=1 the next cycle.
- Hold eu_ready_i=0 for 3 cycles with two READY entries. Required: eu_valid_o and the outputs stay stable on entry 0. Release eu_ready_i. Required: entry 1 is dispatched the next cycle.
- Send eu_except_raised_i=1, code E_ILLEGAL_INSTRUCTION, for dest 4. Required: cdb_except_raised_o=1 with the same code on idx 4.
- Assert flush_i with entries in WAIT_OPS, EXECUTING and COMPLETED. Required: eu_valid_o=0, cdb_valid_o=0, issue_ready_o=1 in the next cycle, and a late eu_valid_i is ignored.
